// File: rtl/booth_mult_seq_if.sv
// Bundle between the Booth controller, its requester and the external add/sub stage.
// The master side requests products and hosts the add/sub stage; the slave side is the controller.
interface booth_mult_seq_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       adder_a;
    logic [WIDTH-1:0]       adder_b;
    logic                   adder_sel0;
    logic                   adder_sel1;
    logic [WIDTH-1:0]       adder_out;

    modport master (
        output start, multiplicand, multiplier, adder_out,
        input  busy, done, product, adder_a, adder_b, adder_sel0, adder_sel1
    );

    modport slave (
        input  start, multiplicand, multiplier, adder_out,
        output busy, done, product, adder_a, adder_b, adder_sel0, adder_sel1
    );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth controller: drives an external add/sub stage for WIDTH
// iterations and exposes the signed product {A,Q}.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    booth_mult_seq_if.slave    bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sel0, sel1;
    logic             ovf;
    logic             sign;
    logic [WIDTH-1:0] r;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sel0 = 1'b1;
        sel1 = 1'b0;
        if (state_q == S_RUN) begin
            case ({q_q[0], q1_q})
                2'b01:   begin sel0 = 1'b1; sel1 = 1'b1; end
                2'b10:   begin sel0 = 1'b0; sel1 = 1'b1; end
                default: begin sel0 = 1'b1; sel1 = 1'b0; end
            endcase
        end
    end

    // The stage result is only WIDTH bits; recover the true sign when A+/-M overflowed.
    always_comb begin
        r    = bus.adder_out;
        ovf  = 1'b0;
        if (sel1 && sel0)
            ovf = (a_q[WIDTH-1] == m_q[WIDTH-1]) && (r[WIDTH-1] != a_q[WIDTH-1]);
        else if (sel1)
            ovf = (a_q[WIDTH-1] != m_q[WIDTH-1]) && (r[WIDTH-1] != a_q[WIDTH-1]);
        sign = r[WIDTH-1] ^ ovf;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = {sign, r[WIDTH-1:1]};
                q_d   = {r[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.product    = {a_q, q_q};
    assign bus.adder_a    = a_q;
    assign bus.adder_b    = m_q;
    assign bus.adder_sel0 = sel0;
    assign bus.adder_sel1 = sel1;
endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench: a plain-arithmetic product model plus a bit-pair Booth decode model,
// compared against the controller every cycle; directed corner cases and random operations.
module tb_booth_mult_seq;
    localparam int W = 32;

    logic clk;
    logic reset;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // External add/sub stage: sel1 picks arithmetic vs pass-through, sel0 picks add vs subtract.
    assign bus.adder_out = bus.adder_sel1 ?
                           (bus.adder_sel0 ? bus.adder_a + bus.adder_b : bus.adder_a - bus.adder_b) :
                           bus.adder_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the product is the signed 64-bit product of the captured operands,
    // delivered WIDTH edges after acceptance; iteration i decodes multiplier bits i and i-1.
    bit              mdl_run;
    bit              mdl_done;
    int              mdl_iter;
    logic [W-1:0]    mdl_m;
    logic [W-1:0]    mdl_q;
    logic [63:0]     mdl_prod;
    bit              mdl_prod_valid;

    function automatic logic [63:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
        longint pm;
        longint pq;
        pm = longint'($signed(m));
        pq = longint'($signed(q));
        return 64'(pm * pq);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mdl_run        = 1'b0;
            mdl_done       = 1'b0;
            mdl_iter       = 0;
            mdl_prod       = '0;
            mdl_prod_valid = 1'b1;
        end else if (mdl_run) begin
            if (mdl_iter == W - 1) begin
                mdl_run        = 1'b0;
                mdl_done       = 1'b1;
                mdl_prod       = ref_mul(mdl_m, mdl_q);
                mdl_prod_valid = 1'b1;
            end else begin
                mdl_iter++;
            end
        end else begin
            mdl_done = 1'b0;
            if (bus.start) begin
                mdl_run        = 1'b1;
                mdl_iter       = 0;
                mdl_m          = bus.multiplicand;
                mdl_q          = bus.multiplier;
                mdl_prod_valid = 1'b0;
            end
        end
    end

    bit model_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        if (model_ready) begin
            logic [1:0] pair;
            logic       exp_sel0;
            logic       exp_sel1;
            check("busy", 64'(bus.busy), 64'(mdl_run));
            check("done", 64'(bus.done), 64'(mdl_done));
            if (mdl_prod_valid)
                check("product", bus.product, mdl_prod);
            exp_sel0 = 1'b1;
            exp_sel1 = 1'b0;
            if (mdl_run) begin
                pair = {mdl_q[mdl_iter], (mdl_iter == 0) ? 1'b0 : mdl_q[mdl_iter-1]};
                exp_sel1 = (pair == 2'b01) || (pair == 2'b10);
                exp_sel0 = (pair != 2'b10);
                check("adder_b", 64'(bus.adder_b), 64'(mdl_m));
            end
            check("sel0", 64'(bus.adder_sel0), 64'(exp_sel0));
            check("sel1", 64'(bus.adder_sel1), 64'(exp_sel1));
        end
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n = i;
                break;
            end
        end
        if (n < 0)
            check("done_timeout", 64'd0, 64'd1);
    endtask

    // Single start pulse; optionally pins the product to a hand-computed literal.
    task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q,
                         input bit has_lit, input logic [63:0] lit, input string name);
        int n;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = m;
        bus.multiplier   = q;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        if (has_lit) begin
            check({name, "_latency"}, 64'(n), 64'd32);
            check({name, "_lit"}, bus.product, lit);
            check({name, "_model"}, ref_mul(m, q), lit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ops_m [5];
        logic [W-1:0] ops_q [5];

        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (2) @(negedge clk);
        model_ready = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_product", bus.product, 64'd0);
        check("rst_sel0", 64'(bus.adder_sel0), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);

        do_op(32'd3, 32'd5, 1'b1, 64'h0000_0000_0000_000F, "m3q5");
        do_op(32'hFFFF_FFF9, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6, "neg7x6");
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "min_x_min");
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "max_x_min");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "neg1_x_neg1");
        do_op(32'd0, 32'd0, 1'b1, 64'd0, "zero");

        // Start during RUN must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'hFFFF_FFF9; bus.multiplier = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd1234; bus.multiplier = 32'd777;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("ignore_start_lit", bus.product, 64'hFFFF_FFFF_FFFF_FFD6);
        repeat (3) @(negedge clk);

        // Reset mid-operation abandons it.
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = 32'd99; bus.multiplier = 32'd101;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (16) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_product", bus.product, 64'd0);
        repeat (40) @(negedge clk);
        do_op(32'd99, 32'd101, 1'b1, 64'd9999, "after_abort");

        // Start held high: back-to-back operations every 33 cycles.
        ops_m[0] = 32'd3;         ops_q[0] = 32'd5;
        ops_m[1] = 32'hFFFF_FFF9; ops_q[1] = 32'd6;
        ops_m[2] = 32'h8000_0000; ops_q[2] = 32'h8000_0000;
        ops_m[3] = 32'h7FFF_FFFF; ops_q[3] = 32'h8000_0000;
        ops_m[4] = 32'h1234_5678; ops_q[4] = 32'hFEDC_BA98;
        @(negedge clk);
        bus.start = 1'b1; bus.multiplicand = ops_m[0]; bus.multiplier = ops_q[0];
        for (int i = 0; i < 5; i++) begin
            wait_done(n);
            check("b2b_spacing", 64'(n), 64'd33);
            check("b2b_product", bus.product, ref_mul(ops_m[i], ops_q[i]));
            @(negedge clk);
            if (i < 4) begin
                bus.multiplicand = ops_m[i+1];
                bus.multiplier   = ops_q[i+1];
            end else begin
                bus.start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);

        // Random operations with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            logic [W-1:0] rm;
            logic [W-1:0] rq;
            rm = $urandom;
            rq = $urandom;
            if ($urandom_range(0, 5) == 0) rm = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) rq = 32'h8000_0000;
            do_op(rm, rq, 1'b0, 64'd0, "rand");
            check("rand_product", bus.product, ref_mul(rm, rq));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
